// File: rtl/semi_turn_executor.sv
// Turns level-held turn triggers into timed rotation commands and holds off forward motion while a turn runs.
// Build option: define SEMI_TURN_BACK_RIGHT_EN to perform the 180-degree turn by rotating right.
module semi_turn_executor #(
  parameter int CONFIRM_TIME = 20,
  parameter int TURN_90_TIME = 450,
  parameter int SETTLE_TIME  = 50,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       trigger_turn_left,
  input  logic       trigger_turn_right,
  input  logic       trigger_turn_back,
  input  logic       in_move_forward,
  output logic       is_turning,
  output logic       turn_left,
  output logic       turn_right,
  output logic       move_forward,
  output logic [2:0] out_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_ARM    = 3'b001,
    S_TURN   = 3'b010,
    S_SETTLE = 3'b011,
    S_REARM  = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_BACK  = 2'b11
  } dir_t;

  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_TIME - 1);
  localparam logic [CNT_W-1:0] TURN90_LAST  = CNT_W'(TURN_90_TIME - 1);
  localparam logic [CNT_W-1:0] TURN180_LAST = CNT_W'(2 * TURN_90_TIME - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_TIME - 1);

`ifdef SEMI_TURN_BACK_RIGHT_EN
  localparam logic BACK_RIGHT = 1'b1;
`else
  localparam logic BACK_RIGHT = 1'b0;
`endif

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_trig;
  logic             held_trig;
  logic [CNT_W-1:0] turn_last;

  assign any_trig  = trigger_turn_left | trigger_turn_right | trigger_turn_back;
  assign turn_last = (dir_q == DIR_BACK) ? TURN180_LAST : TURN90_LAST;

  // Only the trigger that was latched on entry can keep ARM alive.
  always_comb begin
    held_trig = 1'b0;
    case (dir_q)
      DIR_LEFT:  held_trig = trigger_turn_left;
      DIR_RIGHT: held_trig = trigger_turn_right;
      DIR_BACK:  held_trig = trigger_turn_back;
      default:   held_trig = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        dir_d = DIR_NONE;
        if (any_trig) begin
          state_d = S_ARM;
          if (trigger_turn_back)      dir_d = DIR_BACK;
          else if (trigger_turn_left) dir_d = DIR_LEFT;
          else                        dir_d = DIR_RIGHT;
        end
      end
      S_ARM: begin
        if (!held_trig) begin
          state_d = S_IDLE;
          dir_d   = DIR_NONE;
          cnt_d   = '0;
        end else if (cnt_q == CONFIRM_LAST) begin
          state_d = S_TURN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TURN: begin
        if (cnt_q == turn_last) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_REARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REARM: begin
        cnt_d = '0;
        if (!any_trig) begin
          state_d = S_IDLE;
          dir_d   = DIR_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        dir_d   = DIR_NONE;
        cnt_d   = '0;
      end
    endcase
    if (!enable) begin
      state_d = S_IDLE;
      dir_d   = DIR_NONE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from the state flops so an async reset silences rotation at once.
  always_comb begin
    is_turning   = (state_q == S_ARM) || (state_q == S_TURN) || (state_q == S_SETTLE);
    turn_left    = 1'b0;
    turn_right   = 1'b0;
    if (state_q == S_TURN) begin
      turn_left  = (dir_q == DIR_LEFT)  || ((dir_q == DIR_BACK) && !BACK_RIGHT);
      turn_right = (dir_q == DIR_RIGHT) || ((dir_q == DIR_BACK) &&  BACK_RIGHT);
    end
    move_forward = in_move_forward && (state_q == S_IDLE);
    out_state    = state_q;
  end

endmodule

// File: tb/tb_semi_turn_executor.sv
// Directed bench for semi_turn_executor with small timing parameters; per-scenario expectations
// are queued before stimulus and compared against counts observed while the scenario runs.
module tb_semi_turn_executor;

  localparam int CONFIRM = 4;
  localparam int T90     = 10;
  localparam int SETTLE  = 3;

`ifdef SEMI_TURN_BACK_RIGHT_EN
  localparam int BACK_ON_RIGHT = 1;
`else
  localparam int BACK_ON_RIGHT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       trigger_turn_left;
  logic       trigger_turn_right;
  logic       trigger_turn_back;
  logic       in_move_forward;
  logic       is_turning;
  logic       turn_left;
  logic       turn_right;
  logic       move_forward;
  logic [2:0] out_state;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    string tag;
    int    first_busy;
    int    busy;
    int    left;
    int    right;
    int    fwd;
    int    rearm;
    int    final_state;
    int    final_fwd;
  } exp_t;

  exp_t sb[$];

  semi_turn_executor #(
    .CONFIRM_TIME(CONFIRM),
    .TURN_90_TIME(T90),
    .SETTLE_TIME (SETTLE),
    .CNT_W       (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .trigger_turn_left (trigger_turn_left),
    .trigger_turn_right(trigger_turn_right),
    .trigger_turn_back (trigger_turn_back),
    .in_move_forward   (in_move_forward),
    .is_turning        (is_turning),
    .turn_left         (turn_left),
    .turn_right        (turn_right),
    .move_forward      (move_forward),
    .out_state         (out_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp)
      $display("check %-28s observed=%0d expected=%0d ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Push expectations, raise the given triggers for 'hold' sampled cycles, then drop them
  // and compare the recorded behaviour against the popped entry.
  task automatic run_case(input string tag, input logic l, input logic r, input logic b,
                          input int hold, input int e_busy, input int e_left,
                          input int e_right, input int e_rearm);
    exp_t e;
    exp_t x;
    int   first_busy = 0;
    int   busy = 0, lc = 0, rc = 0, fc = 0, rearm = 0;
    e.tag = tag; e.first_busy = 1; e.busy = e_busy; e.left = e_left; e.right = e_right;
    e.fwd = 0; e.rearm = e_rearm; e.final_state = 0; e.final_fwd = 1;
    sb.push_back(e);
    @(negedge clk);
    trigger_turn_left  = l;
    trigger_turn_right = r;
    trigger_turn_back  = b;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == 1) first_busy = int'(is_turning);
      busy  += int'(is_turning);
      lc    += int'(turn_left);
      rc    += int'(turn_right);
      fc    += int'(move_forward);
      rearm += int'(out_state == 3'b100);
      if (turn_left && turn_right) chk({tag, ".both_rot"}, 1, 0);
    end
    trigger_turn_left  = 1'b0;
    trigger_turn_right = 1'b0;
    trigger_turn_back  = 1'b0;
    @(negedge clk);
    x = sb.pop_front();
    chk({x.tag, ".first_busy"}, first_busy, x.first_busy);
    chk({x.tag, ".busy_cycles"}, busy, x.busy);
    chk({x.tag, ".left_cycles"}, lc, x.left);
    chk({x.tag, ".right_cycles"}, rc, x.right);
    chk({x.tag, ".fwd_cycles"}, fc, x.fwd);
    chk({x.tag, ".rearm_cycles"}, rearm, x.rearm);
    chk({x.tag, ".final_state"}, int'(out_state), x.final_state);
    chk({x.tag, ".final_fwd"}, int'(move_forward), x.final_fwd);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    trigger_turn_left = 1'b0;
    trigger_turn_right = 1'b0;
    trigger_turn_back = 1'b0;
    in_move_forward = 1'b0;
    #2;
    chk("reset.state", int'(out_state), 0);
    chk("reset.is_turning", int'(is_turning), 0);
    chk("reset.rotation", int'({turn_left, turn_right}), 0);
    chk("reset.move_forward", int'(move_forward), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_move_forward = 1'b1;
    @(negedge clk);
    chk("idle.move_forward", int'(move_forward), 1);

    // 90-degree turns: ARM CONFIRM + TURN T90 + SETTLE cycles busy, rest of hold in REARM.
    run_case("left_hold30", 1, 0, 0, 30, CONFIRM + T90 + SETTLE, T90, 0,
             30 - (CONFIRM + T90 + SETTLE));
    run_case("right_hold30", 0, 1, 0, 30, CONFIRM + T90 + SETTLE, 0, T90,
             30 - (CONFIRM + T90 + SETTLE));
    run_case("back_hold30", 0, 0, 1, 30, CONFIRM + 2 * T90 + SETTLE,
             BACK_ON_RIGHT ? 0 : 2 * T90, BACK_ON_RIGHT ? 2 * T90 : 0,
             30 - (CONFIRM + 2 * T90 + SETTLE));
    run_case("right_pulse2", 0, 1, 0, 2, 2, 0, 0, 0);
    run_case("all_three", 1, 1, 1, 30, CONFIRM + 2 * T90 + SETTLE,
             BACK_ON_RIGHT ? 0 : 2 * T90, BACK_ON_RIGHT ? 2 * T90 : 0,
             30 - (CONFIRM + 2 * T90 + SETTLE));

    // Enable dropped in the middle of a left turn.
    @(negedge clk);
    trigger_turn_left = 1'b1;
    repeat (CONFIRM + 2) @(negedge clk);
    chk("en_low.pre_state", int'(out_state), 2);
    chk("en_low.pre_fwd", int'(move_forward), 0);
    enable = 1'b0;
    @(negedge clk);
    chk("en_low.state", int'(out_state), 0);
    chk("en_low.turn_left", int'(turn_left), 0);
    chk("en_low.move_forward", int'(move_forward), 1);
    @(negedge clk);
    chk("en_low.held_trig_state", int'(out_state), 0);
    trigger_turn_left = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset asserted mid-cycle during rotation.
    in_move_forward = 1'b0;
    trigger_turn_left = 1'b1;
    repeat (CONFIRM + 2) @(negedge clk);
    chk("arst.pre_turn_left", int'(turn_left), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.turn_left", int'(turn_left), 0);
    chk("arst.is_turning", int'(is_turning), 0);
    chk("arst.state", int'(out_state), 0);
    trigger_turn_left = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst.after_state", int'(out_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
